modn_down_ctr: RTL and testbench

//   Loadable mod-N down-counter: the count-down counterpart of the mod-N up-counter.
//   A start value is accepted over a valid/ready load handshake.
//   The block counts down to 0 on enabled cycles, then pulses terminal-count (tc).
//   It then either reloads (auto-reload mode) or returns to idle.

---
 rtl/modn_down_ctr.sv | 96 +++++++++
 tb/tb_modn_down_ctr.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/modn_down_ctr.sv
// Loadable mod-N down-counter with valid/ready start-value load, count enable,
// synchronous abort and optional auto-reload after the terminal-count pulse.
module modn_down_ctr #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             en,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Out-of-range start values saturate at the top legal count.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // State and datapath registers; reset returns to IDLE with a zero count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next state: abort beats counting, counting beats loading; tc defaults low.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      out_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            out_d    = clamp(load_value);
            reload_d = clamp(load_value);
            state_d  = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (out_q != '0) begin
              out_d = out_q - WIDTH'(1);
            end else begin
              // Terminal edge: auto_reload is only looked at here.
              tc_d = 1'b1;
              if (auto_reload) begin
                out_d = reload_q;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and status are decoded straight from the state register.
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign out        = out_q;
  assign tc         = tc_q;

endmodule

// File: tb/tb_modn_down_ctr.sv
// Directed bench for modn_down_ctr (N=10, WIDTH=4): per-cycle model compare
// plus hand-computed literal checks for each scenario.
module tb_modn_down_ctr;

  localparam int N = 10;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic             auto_reload = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             load_ready;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tc;

  int vectors = 0;
  int miscompares = 0;

  modn_down_ctr #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .auto_reload(auto_reload),
    .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
    .out(out), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  // Model: a run is "start value V, k enabled edges taken so far"; the count
  // shown is V-k, the edge with k==V is terminal. Idle always shows 0.
  logic m_run = 1'b0;
  int   m_v = 0;
  int   m_steps = 0;
  logic m_tc = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run   <= 1'b0;
      m_v     <= 0;
      m_steps <= 0;
      m_tc    <= 1'b0;
    end else begin
      m_tc <= 1'b0;
      if (abort) begin
        m_run <= 1'b0;
      end else if (m_run) begin
        if (en) begin
          if (m_steps == m_v) begin
            m_tc <= 1'b1;
            if (auto_reload) m_steps <= 0;
            else m_run <= 1'b0;
          end else begin
            m_steps <= m_steps + 1;
          end
        end
      end else if (load_valid) begin
        m_v     <= (int'(load_value) > N - 1) ? N - 1 : int'(load_value);
        m_steps <= 0;
        m_run   <= 1'b1;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_out;
    exp_out = m_run ? WIDTH'(m_v - m_steps) : '0;
    vectors++;
    if (out !== exp_out || busy !== m_run || load_ready !== !m_run || tc !== m_tc) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t: got out=%0d busy=%b rdy=%b tc=%b expected out=%0d busy=%b rdy=%b tc=%b",
               $time, out, busy, load_ready, tc, exp_out, m_run, !m_run, m_tc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("chk %s = %0d ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v, input logic ar);
    load_valid  = 1'b1;
    load_value  = WIDTH'(v);
    auto_reload = ar;
    en          = 1'b1;
    tick();
    load_valid  = 1'b0;
  endtask

  initial begin
    int tcs;
    int edges;
    int busy_ok;
    #1 rst = 1'b0;
    #11 rst = 1'b1;
    #1;
    check("reset_out", int'(out), 0);
    check("reset_ready", int'(load_ready), 1);

    // 2. load 5, one-shot
    do_load(5, 1'b0);
    check("t2_load_out", int'(out), 5);
    check("t2_load_busy", int'(busy), 1);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("t2_count", int'(out), i);
    end
    check("t2_tc_before", int'(tc), 0);
    tick();
    check("t2_tc", int'(tc), 1);
    check("t2_idle_busy", int'(busy), 0);
    check("t2_idle_ready", int'(load_ready), 1);
    tick();
    check("t2_tc_clear", int'(tc), 0);

    // 3. load 3, auto-reload for 12 enabled cycles
    do_load(3, 1'b1);
    tcs = 0;
    busy_ok = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      tcs += int'(tc);
      if (!busy) busy_ok = 0;
      if (i == 4) begin
        check("t3_reload_out", int'(out), 3);
        check("t3_first_tc", int'(tc), 1);
      end
    end
    check("t3_tc_count", tcs, 3);
    check("t3_busy_held", busy_ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_out", int'(out), 0);

    // 4. clamp and zero load
    do_load(15, 1'b0);
    check("t4_clamp", int'(out), 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_load(0, 1'b0);
    check("t4_zero_busy", int'(busy), 1);
    tick();
    check("t4_zero_tc", int'(tc), 1);

    // 5. stall: en 1,0,0,1 then high; tc after V+1+2 edges
    do_load(6, 1'b0);
    edges = 0;
    en = 1'b1; tick(); edges++;
    check("t5_after_en1", int'(out), 5);
    en = 1'b0; tick(); edges++;
    en = 1'b0; tick(); edges++;
    check("t5_stall_hold", int'(out), 5);
    en = 1'b1;
    while (!tc && edges < 20) begin
      tick();
      edges++;
    end
    check("t5_tc_edges", edges, 9);

    // 6. abort on terminal edge, abort beats load, load_valid ignored in RUN
    tick();
    do_load(2, 1'b0);
    tick();
    tick();
    check("t6_at_zero", int'(out), 0);
    abort = 1'b1;
    tick();
    check("t6_abort_tc", int'(tc), 0);
    check("t6_abort_busy", int'(busy), 0);
    load_valid = 1'b1;
    load_value = 4'd7;
    tick();
    abort = 1'b0;
    load_valid = 1'b0;
    check("t6_load_refused", int'(busy), 0);
    check("t6_refused_out", int'(out), 0);
    do_load(4, 1'b0);
    load_valid = 1'b1;
    load_value = 4'd7;
    tick();
    load_valid = 1'b0;
    check("t6_run_ignores_load", int'(out), 3);

    // 1. async reset mid-count, checked before any clock edge
    tick();
    #2 rst = 1'b0;
    #1;
    check("t1_async_out", int'(out), 0);
    check("t1_async_busy", int'(busy), 0);
    check("t1_async_tc", int'(tc), 0);
    check("t1_async_ready", int'(load_ready), 1);
    tick();
    #3 rst = 1'b1;
    tick();
    do_load(1, 1'b0);
    check("t1_post_reset_load", int'(out), 1);
    tick();
    tick();
    check("t1_post_reset_tc", int'(tc), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
